// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger generator, its Wishbone front-end and the detector bench.
// State encodings and default field sizes live here so every consumer agrees on them.
package trigger_pkg;

  localparam int unsigned TRG_TICK_DIV = 50;
  localparam int unsigned TRG_WIDTH_W  = 8;
  localparam int unsigned TRG_PERIOD_W = 16;

  typedef enum logic [1:0] {
    TRG_IDLE  = 2'd0,
    TRG_PULSE = 2'd1,
    TRG_GAP   = 2'd2
  } trg_state_t;

endpackage

// File: rtl/trigger_gen_if.sv
// Control/status bundle between the register front-end (master) and trigger_gen (slave).
interface trigger_gen_if
  import trigger_pkg::*;
#(
  parameter int WIDTH_W  = TRG_WIDTH_W,
  parameter int PERIOD_W = TRG_PERIOD_W
);

  // Handshake: start is a one-cycle request taken only while busy=0 (IDLE) and stop=0;
  // there is no ready, a request seen while busy is simply dropped. stop is level-honoured
  // in every state. done is a one-cycle strobe per completed period.
  logic                start;
  logic                stop;
  logic                continuous;
  logic [WIDTH_W-1:0]  width;
  logic [PERIOD_W-1:0] period;
  logic                trig_out;
  logic                busy;
  logic                done;
  trg_state_t          dbg_state;

  modport master (
    output start, stop, continuous, width, period,
    input  trig_out, busy, done, dbg_state
  );

  modport slave (
    input  start, stop, continuous, width, period,
    output trig_out, busy, done, dbg_state
  );

endinterface

// File: rtl/tick_prescaler.sv
// Divides the enabled clock into a one-cycle tick every DIV cycles.
module tick_prescaler #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (clr || sync_clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/trigger_gen.sv
// Programmable pulse-train generator: pulse width and period counted in prescaled ticks,
// one-shot or continuous, with abort and a per-period done strobe.
module trigger_gen
  import trigger_pkg::*;
#(
  parameter int TICK_DIV = TRG_TICK_DIV,
  parameter int WIDTH_W  = TRG_WIDTH_W,
  parameter int PERIOD_W = TRG_PERIOD_W
) (
  input  logic            clk,
  input  logic            clr,
  trigger_gen_if.slave    bus
);

  localparam int CNT_W = PERIOD_W + 1;

  trg_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [CNT_W-1:0] w_l, p_l;
  logic [WIDTH_W-1:0] w_eff;
  logic [CNT_W-1:0] w_ext, p_ext, p_eff;
  logic             tick, accept, pulse_end, period_end;
  logic             trig_q, busy_c, done_c;

  // Zero width is stretched to one tick, and the period is forced past the width so the
  // gap is never empty.
  assign w_eff = (bus.width == '0) ? WIDTH_W'(1) : bus.width;
  assign w_ext = CNT_W'(w_eff);
  assign p_ext = CNT_W'(bus.period);
  assign p_eff = (p_ext <= w_ext) ? w_ext + 1'b1 : p_ext;

  assign cnt_inc    = cnt + 1'b1;
  assign accept     = (state == TRG_IDLE) && bus.start && !bus.stop;
  assign pulse_end  = (state == TRG_PULSE) && tick && (cnt_inc == w_l);
  assign period_end = (state == TRG_GAP) && tick && (cnt_inc == p_l) && !bus.stop;

  tick_prescaler #(.DIV(TICK_DIV)) u_presc (
    .clk      (clk),
    .clr      (clr),
    .en       (busy_c),
    .sync_clr (accept),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (clr) state <= TRG_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TRG_IDLE: begin
        if (accept) state_next = TRG_PULSE;
      end
      TRG_PULSE: begin
        if (bus.stop)       state_next = TRG_IDLE;
        else if (pulse_end) state_next = TRG_GAP;
      end
      TRG_GAP: begin
        if (bus.stop)        state_next = TRG_IDLE;
        else if (period_end) state_next = bus.continuous ? TRG_PULSE : TRG_IDLE;
      end
      default: state_next = TRG_IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state != TRG_IDLE);
    done_c = period_end && !clr;
  end

  // The tick counter spans the whole period: it is not cleared at the pulse/gap boundary.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt    <= '0;
      w_l    <= '0;
      p_l    <= '0;
      trig_q <= 1'b0;
    end else begin
      if (accept) begin
        w_l <= w_ext;
        p_l <= p_eff;
      end
      if (accept || bus.stop || period_end) cnt <= '0;
      else if (tick)                        cnt <= cnt_inc;
      trig_q <= (state_next == TRG_PULSE);
    end
  end

  assign bus.trig_out  = trig_q;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_trigger_gen.sv
// Scoreboard bench for trigger_gen at TICK_DIV=4: stimulus pushes timed output events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_trigger_gen;
  import trigger_pkg::*;

  localparam int DIV = 4;
  localparam int W   = 32;
  localparam logic [1:0] EV_RISE  = 2'd0;
  localparam logic [1:0] EV_FALL  = 2'd1;
  localparam logic [1:0] EV_DONE  = 2'd2;
  localparam logic [1:0] EV_BFALL = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  trigger_gen_if #(.WIDTH_W(8), .PERIOD_W(16)) bus ();

  trigger_gen #(.TICK_DIV(DIV), .WIDTH_W(8), .PERIOD_W(16)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  function automatic logic [W-1:0] ev(input logic [1:0] k, input int c);
    return {k, c[29:0]};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  logic prev_trig = 1'b0;
  logic prev_busy = 1'b0;

  task automatic observe(input logic [1:0] k);
    logic [W-1:0] act, exp;
    act = ev(k, cyc);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", k, cyc);
    end else begin
      exp = exp_q.pop_front();
      if (act != exp) begin
        n_fail++;
        $display("FAIL event: got kind %0d cycle %0d, expected kind %0d cycle %0d",
                 act[31:30], act[29:0], exp[31:30], exp[29:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.trig_out && !prev_trig) observe(EV_RISE);
      if (!bus.trig_out && prev_trig) observe(EV_FALL);
      if (bus.done) begin
        observe(EV_DONE);
        check("done_with_stop", int'(bus.stop), 0);
      end
      if (!bus.busy && prev_busy) observe(EV_BFALL);
    end
    prev_trig = bus.trig_out;
    prev_busy = bus.busy;
  end

  // receive-side detector model: t_long sampled on t_short (every DIV/2 cycles), 2-sample qualify
  int   fires = 0;
  logic s_cur = 1'b0, s_prev = 1'b0, qual_d = 1'b0;
  always @(posedge clk) begin
    if (cyc % (DIV / 2) == 0) begin
      s_prev = s_cur;
      s_cur  = bus.trig_out;
      if (s_cur && s_prev && !qual_d) fires++;
      qual_d = s_cur && s_prev;
    end
  end

  // driver: one run of nper periods; wl/pl are the hand-derived effective tick counts
  task automatic run(input int w, input int p, input bit cont, input int nper,
                     input int wl, input int pl, input bit meddle);
    int n, pc, wc;
    pc = pl * DIV;
    wc = wl * DIV;
    @(posedge clk); #1;
    n = cyc;
    bus.start = 1'b1; bus.width = w[7:0]; bus.period = p[15:0]; bus.continuous = cont;
    for (int k = 0; k < nper; k++) begin
      exp_q.push_back(ev(EV_RISE, n + k * pc + 1));
      exp_q.push_back(ev(EV_FALL, n + k * pc + wc + 1));
      exp_q.push_back(ev(EV_DONE, n + (k + 1) * pc));
    end
    exp_q.push_back(ev(EV_BFALL, n + nper * pc + 1));
    while (cyc < n + nper * pc + 3) begin
      @(posedge clk); #1;
      bus.start = meddle && (cyc == n + 5);
      if (meddle && cyc == n + 6) begin
        bus.width  = 8'd7;
        bus.period = 16'd1;
      end
      if (cont && cyc == n + (nper - 1) * pc + 3) bus.continuous = 1'b0;
    end
    check("idle_after_run", int'(bus.busy), 0);
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.stop = 1'b0; bus.continuous = 1'b0;
    bus.width = '0;   bus.period = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_trig", int'(bus.trig_out), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_state", int'(bus.dbg_state), int'(TRG_IDLE));
    clr = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    // clr held 3 cycles mid-pulse
    @(posedge clk); #1;
    n = cyc;
    bus.start = 1'b1; bus.width = 8'd4; bus.period = 16'd8;
    exp_q.push_back(ev(EV_RISE, n + 1));
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    clr = 1'b1;
    exp_q.push_back(ev(EV_FALL, n + 6));
    exp_q.push_back(ev(EV_BFALL, n + 6));
    @(posedge clk); #1;
    check("clr_trig", int'(bus.trig_out), 0);
    check("clr_busy", int'(bus.busy), 0);
    check("clr_done", int'(bus.done), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("clr_stays_idle", int'(bus.busy), 0);

    // one-shot width=3 period=10: high 12, done at +40, busy falls at +41
    run(3, 10, 1'b0, 1, 3, 10, 1'b0);
    // continuous width=2 period=5: four periods, then three periods
    run(2, 5, 1'b1, 4, 2, 5, 1'b0);
    run(2, 5, 1'b1, 3, 2, 5, 1'b0);
    // boundaries
    run(0, 0, 1'b0, 1, 1, 2, 1'b0);
    run(5, 5, 1'b0, 1, 5, 6, 1'b0);

    // stop during PULSE
    @(posedge clk); #1;
    n = cyc;
    bus.start = 1'b1; bus.width = 8'd4; bus.period = 16'd8; bus.continuous = 1'b0;
    exp_q.push_back(ev(EV_RISE, n + 1));
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.stop = 1'b1;
    exp_q.push_back(ev(EV_FALL, n + 7));
    exp_q.push_back(ev(EV_BFALL, n + 7));
    @(posedge clk); #1;
    bus.stop = 1'b0;
    check("stop_pulse_trig", int'(bus.trig_out), 0);
    check("stop_pulse_busy", int'(bus.busy), 0);
    repeat (50) @(posedge clk);

    // stop during GAP
    @(posedge clk); #1;
    n = cyc;
    bus.start = 1'b1; bus.width = 8'd1; bus.period = 16'd8;
    exp_q.push_back(ev(EV_RISE, n + 1));
    exp_q.push_back(ev(EV_FALL, n + 5));
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.stop = 1'b1;
    exp_q.push_back(ev(EV_BFALL, n + 11));
    @(posedge clk); #1;
    bus.stop = 1'b0;
    check("stop_gap_state", int'(bus.dbg_state), int'(TRG_IDLE));
    repeat (50) @(posedge clk);

    // stop together with start in IDLE: nothing starts
    @(posedge clk); #1;
    bus.start = 1'b1; bus.stop = 1'b1; bus.width = 8'd3; bus.period = 16'd10;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.stop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("stop_start_busy", int'(bus.busy), 0);
      check("stop_start_trig", int'(bus.trig_out), 0);
      @(posedge clk); #1;
    end

    // restart and width change while busy are ignored; detector sees one fire per pulse
    repeat (4) @(posedge clk);
    fires = 0;
    run(2, 4, 1'b1, 3, 2, 4, 1'b1);
    check("detector_fires", fires, 3);

    repeat (10) @(posedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
